rcon_seq_gen: RTL and testbench



---
 rtl/aes_pkg.sv | 47 ++++
 rtl/gf_xtime.sv | 24 ++
 rtl/rcon_seq_gen.sv | 183 ++++++++++++++++++
 tb/tb_rcon_seq_gen.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants: key-size encodings, round-constant seeds and polynomials,
// step counts and the Rcon generator state type.
package aes_pkg;

    localparam logic [1:0] MODE_128  = 2'b00;
    localparam logic [1:0] MODE_192  = 2'b01;
    localparam logic [1:0] MODE_256  = 2'b10;
    localparam logic [1:0] MODE_RSVD = 2'b11;

    localparam logic [7:0] RCON_FIRST    = 8'h01;
    localparam logic [7:0] RCON_POLY     = 8'h1b;
    localparam logic [7:0] RCON_INV_POLY = 8'h8d;

    localparam logic [3:0] STEPS_128 = 4'd10;
    localparam logic [3:0] STEPS_192 = 4'd8;
    localparam logic [3:0] STEPS_256 = 4'd7;

    localparam logic [7:0] RCON_LAST_128 = 8'h36;
    localparam logic [7:0] RCON_LAST_192 = 8'h80;
    localparam logic [7:0] RCON_LAST_256 = 8'h40;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } rcon_state_e;

    // Number of key-expansion steps for a key size; reserved maps to AES-128.
    function automatic logic [3:0] step_count(input logic [1:0] mode);
        case (mode)
            MODE_128: step_count = STEPS_128;
            MODE_192: step_count = STEPS_192;
            MODE_256: step_count = STEPS_256;
            default:  step_count = STEPS_128;
        endcase
    endfunction

    // Final Rcon byte of a key size, used as the seed of a reverse sequence.
    function automatic logic [7:0] rcon_last(input logic [1:0] mode);
        case (mode)
            MODE_128: rcon_last = RCON_LAST_128;
            MODE_192: rcon_last = RCON_LAST_192;
            MODE_256: rcon_last = RCON_LAST_256;
            default:  rcon_last = RCON_LAST_128;
        endcase
    endfunction

endpackage

// File: rtl/gf_xtime.sv
// GF(2^8) multiply-by-x (xtime) and its inverse, reusable by MixColumns.
module gf_xtime
    import aes_pkg::*;
(
    input  logic       i_inv,
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    logic [7:0] w_fwd;
    logic [7:0] w_inv;

    // Inverse reduction folds the low bit back in via x^-1 = 0x8d.
    always_comb begin
        w_fwd = {i_byte[6:0], 1'b0} ^ (i_byte[7] ? RCON_POLY : 8'h00);
        w_inv = {1'b0, i_byte[7:1]} ^ (i_byte[0] ? RCON_INV_POLY : 8'h00);
        if (i_inv) begin
            o_byte = w_inv;
        end else begin
            o_byte = w_fwd;
        end
    end

endmodule

// File: rtl/rcon_seq_gen.sv
// Streams one AES Rcon word per key-expansion step over valid/ready, forward or
// reverse, computing each value iteratively from the previous one.
module rcon_seq_gen
    import aes_pkg::*;
#(
    parameter int WORD_W     = 32,
    parameter int REVERSE_EN = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic              reverse,
    input  logic              abort,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [WORD_W-1:0] rcon_out,
    output logic [3:0]        step_idx,
    output logic              last,
    output logic              busy,
    output logic              done,
    output logic              err
);

    rcon_state_e r_state;
    logic [1:0]  r_mode;
    logic        r_rev;
    logic [7:0]  r_rc;
    logic [3:0]  r_step;
    logic        r_valid;
    logic        r_last;
    logic        r_busy;
    logic        r_done;
    logic        r_err;

    rcon_state_e w_state_nxt;
    logic [1:0]  w_mode_nxt;
    logic        w_rev_nxt;
    logic [7:0]  w_rc_nxt;
    logic [3:0]  w_step_nxt;
    logic        w_valid_nxt;
    logic        w_last_nxt;
    logic        w_busy_nxt;
    logic        w_done_nxt;
    logic        w_err_nxt;

    logic        w_rev_in;
    logic        w_hs;
    logic [7:0]  w_rc_adv;
    logic [3:0]  w_start_steps;
    logic [3:0]  w_last_idx;
    logic [3:0]  w_step_inc;
    logic [3:0]  w_step_dec;

    assign w_rev_in      = (REVERSE_EN != 0) ? reverse : 1'b0;
    assign w_hs          = r_valid & out_ready;
    assign w_start_steps = step_count(mode);
    assign w_last_idx    = step_count(r_mode) - 4'd1;
    assign w_step_inc    = r_step + 4'd1;
    assign w_step_dec    = r_step - 4'd1;

    gf_xtime u_xtime (
        .i_inv  (r_rev),
        .i_byte (r_rc),
        .o_byte (w_rc_adv)
    );

    // Next-state logic: IDLE accepts start, RUN advances on each handshake.
    always_comb begin
        w_state_nxt = r_state;
        w_mode_nxt  = r_mode;
        w_rev_nxt   = r_rev;
        w_rc_nxt    = r_rc;
        w_step_nxt  = r_step;
        w_valid_nxt = r_valid;
        w_last_nxt  = r_last;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && !abort) begin
                    if (mode == MODE_RSVD) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_RUN;
                        w_mode_nxt  = mode;
                        w_rev_nxt   = w_rev_in;
                        w_valid_nxt = 1'b1;
                        w_busy_nxt  = 1'b1;
                        w_last_nxt  = 1'b0;
                        if (w_rev_in) begin
                            w_rc_nxt   = rcon_last(mode);
                            w_step_nxt = w_start_steps - 4'd1;
                        end else begin
                            w_rc_nxt   = RCON_FIRST;
                            w_step_nxt = 4'd0;
                        end
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                    w_valid_nxt = 1'b0;
                    w_busy_nxt  = 1'b0;
                    w_last_nxt  = 1'b0;
                end else if (w_hs) begin
                    if (r_last) begin
                        w_state_nxt = ST_IDLE;
                        w_valid_nxt = 1'b0;
                        w_busy_nxt  = 1'b0;
                        w_last_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_rc_nxt = w_rc_adv;
                        if (r_rev) begin
                            w_step_nxt = w_step_dec;
                            w_last_nxt = (w_step_dec == 4'd0);
                        end else begin
                            w_step_nxt = w_step_inc;
                            w_last_nxt = (w_step_inc == w_last_idx);
                        end
                    end
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_valid_nxt = 1'b0;
                w_busy_nxt  = 1'b0;
                w_last_nxt  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_mode  <= 2'b00;
            r_rev   <= 1'b0;
            r_rc    <= 8'h00;
            r_step  <= 4'd0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_mode  <= w_mode_nxt;
            r_rev   <= w_rev_nxt;
            r_rc    <= w_rc_nxt;
            r_step  <= w_step_nxt;
            r_valid <= w_valid_nxt;
            r_last  <= w_last_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // The Rcon byte sits in the top byte of the word; the rest is zero.
    generate
        if (WORD_W == 8) begin : g_byte_word
            assign rcon_out = r_rc;
        end else begin : g_wide_word
            assign rcon_out = {r_rc, {(WORD_W-8){1'b0}}};
        end
    endgenerate

    assign out_valid = r_valid;
    assign step_idx  = r_step;
    assign last      = r_last;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;

endmodule

// File: tb/tb_rcon_seq_gen.sv
// Scoreboard bench for rcon_seq_gen: expected words are queued at start and
// compared as the DUT hands them over.
`timescale 1ns/1ps
module tb_rcon_seq_gen;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   mode = 2'b00;
    logic         reverse = 1'b0;
    logic         abort = 1'b0;
    logic         out_ready = 1'b0;
    logic         out_valid;
    logic [W-1:0] rcon_out;
    logic [3:0]   step_idx;
    logic         last;
    logic         busy;
    logic         done;
    logic         err;

    typedef struct packed {
        logic [7:0] rc;
        logic [3:0] idx;
        logic       lst;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    logic [7:0] fwd_tab [0:9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                  8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    rcon_seq_gen #(.WORD_W(W), .REVERSE_EN(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mode      (mode),
        .reverse   (reverse),
        .abort     (abort),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .rcon_out  (rcon_out),
        .step_idx  (step_idx),
        .last      (last),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic push_expected(input logic [1:0] m, input logic rv);
        int n;
        int idx;
        exp_t e;
        n = (m == 2'b00) ? 10 : (m == 2'b01) ? 8 : 7;
        for (int k = 0; k < n; k++) begin
            idx   = rv ? (n - 1 - k) : k;
            e.rc  = fwd_tab[idx];
            e.idx = idx[3:0];
            e.lst = (k == n - 1);
            sb_q.push_back(e);
        end
    endtask

    task automatic start_seq(input logic [1:0] m, input logic rv);
        @(posedge clk); #1;
        start = 1'b1; mode = m; reverse = rv;
        push_expected(m, rv);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({out_valid, rcon_out, step_idx, last, busy, done, err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b rc=%h idx=%0d l=%b b=%b d=%b e=%b required all 0",
                     out_valid, rcon_out, step_idx, last, busy, done, err);
        end
        #2 rst_n = 1'b1;
    endtask

    task automatic test_aes128_fwd();
        int cyc;
        exp_t e;
        out_ready = 1'b1;
        start_seq(2'b00, 1'b0);
        cyc = 0;
        while (sb_q.size() > 0 && cyc < 40) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                e = sb_q.pop_front();
                checks++;
                if (rcon_out[W-1 -: 8] !== e.rc || step_idx !== e.idx || last !== e.lst ||
                    rcon_out[W-9:0] !== '0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL a128_word got rc=%h idx=%0d last=%b busy=%b required rc=%h idx=%0d last=%b",
                             rcon_out, step_idx, last, busy, e.rc, e.idx, e.lst);
                end
            end
            cyc++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL a128_timeout got %0d words left required 0", sb_q.size());
            sb_q.delete();
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || rcon_out[W-1 -: 8] !== 8'h36) begin
            errors++;
            $display("FAIL a128_done got d=%b b=%b v=%b rc=%h required d=1 b=0 v=0 rc=36",
                     done, busy, out_valid, rcon_out[W-1 -: 8]);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL a128_done_pulse got %b required 0", done);
        end
    endtask

    task automatic test_aes256_rev();
        int cyc;
        exp_t e;
        out_ready = 1'b1;
        start_seq(2'b10, 1'b1);
        cyc = 0;
        while (sb_q.size() > 0 && cyc < 40) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                e = sb_q.pop_front();
                checks++;
                if (rcon_out[W-1 -: 8] !== e.rc || step_idx !== e.idx || last !== e.lst) begin
                    errors++;
                    $display("FAIL a256_rev_word got rc=%h idx=%0d last=%b required rc=%h idx=%0d last=%b",
                             rcon_out[W-1 -: 8], step_idx, last, e.rc, e.idx, e.lst);
                end
            end
            cyc++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL a256_rev_timeout got %0d words left required 0", sb_q.size());
            sb_q.delete();
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL a256_rev_done got d=%b b=%b required d=1 b=0", done, busy);
        end
    endtask

    task automatic test_aes192_stall();
        int cyc;
        int words;
        exp_t e;
        logic held;
        logic [W-1:0] h_rc;
        logic [3:0] h_idx;
        logic h_last;
        out_ready = 1'b1;
        start_seq(2'b01, 1'b0);
        cyc = 0; words = 0; held = 1'b0;
        while (sb_q.size() > 0 && cyc < 60) begin
            @(negedge clk);
            if (held) begin
                checks++;
                if (rcon_out !== h_rc || step_idx !== h_idx || last !== h_last || out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL a192_stable got rc=%h idx=%0d last=%b required rc=%h idx=%0d last=%b",
                             rcon_out, step_idx, last, h_rc, h_idx, h_last);
                end
            end
            held = out_valid && !out_ready;
            h_rc = rcon_out; h_idx = step_idx; h_last = last;
            if (out_valid && out_ready) begin
                e = sb_q.pop_front();
                words++;
                checks++;
                if (rcon_out[W-1 -: 8] !== e.rc || step_idx !== e.idx || last !== e.lst) begin
                    errors++;
                    $display("FAIL a192_word got rc=%h idx=%0d last=%b required rc=%h idx=%0d last=%b",
                             rcon_out[W-1 -: 8], step_idx, last, e.rc, e.idx, e.lst);
                end
            end
            cyc++;
            @(posedge clk); #1;
            out_ready = ((cyc % 3) == 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (words != 8 || done !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL a192_count got words=%0d done=%b valid=%b required words=8 done=1 valid=0",
                     words, done, out_valid);
            sb_q.delete();
        end
    endtask

    task automatic test_err();
        @(posedge clk); #1;
        start = 1'b1; mode = 2'b11; reverse = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL err_pulse got e=%b b=%b v=%b required e=1 b=0 v=0", err, busy, out_valid);
        end
        @(negedge clk);
        checks++;
        if (err !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL err_clear got e=%b b=%b v=%b required e=0 b=0 v=0", err, busy, out_valid);
        end
        @(posedge clk); #1;
        start = 1'b1; abort = 1'b1; mode = 2'b00;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL start_with_abort got b=%b v=%b required b=0 v=0", busy, out_valid);
        end
    endtask

    task automatic test_abort();
        int hs;
        int cyc;
        exp_t e;
        out_ready = 1'b1;
        start_seq(2'b00, 1'b0);
        hs = 0; cyc = 0;
        while (hs < 3 && cyc < 20) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                void'(sb_q.pop_front());
                hs++;
            end
            cyc++;
        end
        @(negedge clk);
        e = sb_q.pop_front();
        checks++;
        if (rcon_out[W-1 -: 8] !== e.rc || e.rc !== 8'h08) begin
            errors++;
            $display("FAIL abort_word got rc=%h required rc=%h", rcon_out[W-1 -: 8], e.rc);
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        sb_q.delete();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle got v=%b b=%b d=%b required v=0 b=0 d=0", out_valid, busy, done);
        end
        out_ready = 1'b0;
        start_seq(2'b00, 1'b0);
        @(negedge clk);
        e = sb_q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || rcon_out[W-1 -: 8] !== e.rc || step_idx !== e.idx) begin
            errors++;
            $display("FAIL abort_restart got v=%b rc=%h idx=%0d required v=1 rc=%h idx=%0d",
                     out_valid, rcon_out[W-1 -: 8], step_idx, e.rc, e.idx);
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        out_ready = 1'b1;
        sb_q.delete();
    endtask

    task automatic test_reset_mid();
        int cyc;
        out_ready = 1'b1;
        start_seq(2'b00, 1'b0);
        cyc = 0;
        @(negedge clk);
        while (!(out_valid && rcon_out[W-1 -: 8] == 8'h10) && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, rcon_out, step_idx, last, busy, done, err} !== '0) begin
            errors++;
            $display("FAIL reset_mid got v=%b rc=%h idx=%0d l=%b b=%b d=%b e=%b required all 0",
                     out_valid, rcon_out, step_idx, last, busy, done, err);
        end
        sb_q.delete();
        #2 rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        int cyc;
        exp_t e;
        out_ready = 1'b1;
        start_seq(2'b00, 1'b0);
        start = 1'b1; mode = 2'b01; reverse = 1'b1;
        cyc = 0;
        while (sb_q.size() > 0 && cyc < 40) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                e = sb_q.pop_front();
                checks++;
                if (rcon_out[W-1 -: 8] !== e.rc || step_idx !== e.idx || last !== e.lst) begin
                    errors++;
                    $display("FAIL run_start_ignored got rc=%h idx=%0d last=%b required rc=%h idx=%0d last=%b",
                             rcon_out[W-1 -: 8], step_idx, last, e.rc, e.idx, e.lst);
                end
            end
            cyc++;
        end
        @(posedge clk); #1;
        start = 1'b0;
        sb_q.delete();
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL run_start_done got d=%b b=%b required d=1 b=0", done, busy);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL final_hs_start_ignored got b=%b v=%b required b=0 v=0", busy, out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_aes128_fwd();
        test_aes256_rev();
        test_aes192_stall();
        test_err();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
